// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : control-flow kind / branch funct3 encodings and PC increment.
// Revision  : 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_JAL    = 2'b10,
    KIND_JALR   = 2'b11
  } kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_INC = 4;

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_cmp : combinational branch condition evaluation with illegal detect.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_branch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ:  taken = (rs1 == rs2);
        F3_BNE:  taken = (rs1 != rs2);
        F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
        F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
        F3_BLTU: taken = (rs1 <  rs2);
        F3_BGEU: taken = (rs1 >= rs2);
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_resolve : resolves branch/jump direction and target, flags mispredicts.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       kind,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  kind_e            kind_w;
  logic             cmp_taken, cmp_illegal;
  logic [XLEN-1:0]  pc_plus4, br_target, jalr_sum;
  logic             taken_d, illegal_d, mispredict_d, accept, count_br;
  logic [XLEN-1:0]  target_d, redirect_d;

  logic             out_valid_q, taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0]  target_q, redirect_q;
  logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;

  assign kind_w = kind_e'(kind);

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .is_branch (kind_w == KIND_BRANCH),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .taken     (cmp_taken),
    .illegal   (cmp_illegal)
  );

  assign pc_plus4  = pc + XLEN'(PC_INC);
  assign br_target = pc + imm;
  assign jalr_sum  = rs1 + imm;

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    target_d  = pc_plus4;
    case (kind_w)
      KIND_NONE: ;
      KIND_BRANCH: begin
        illegal_d = cmp_illegal;
        taken_d   = cmp_taken;
        if (!cmp_illegal) target_d = br_target;
      end
      KIND_JAL: begin
        taken_d  = 1'b1;
        target_d = br_target;
      end
      KIND_JALR: begin
        taken_d  = 1'b1;
        target_d = {jalr_sum[XLEN-1:1], 1'b0};
      end
    endcase
  end

  assign mispredict_d = !illegal_d &&
                        ((taken_d != pred_taken) || (taken_d && (target_d != pred_target)));
  assign redirect_d   = taken_d ? target_d : pc_plus4;

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign count_br = (kind_w != KIND_NONE) && !illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      // accept implies !flush, so flush only ever drops the held result
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q  <= 1'b1;
        taken_q      <= taken_d;
        mispredict_q <= mispredict_d;
        illegal_q    <= illegal_d;
        target_q     <= target_d;
        redirect_q   <= redirect_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && count_br && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (accept && mispredict_d && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign illegal     = illegal_q;
  assign br_cnt      = br_cnt_q;
  assign mp_cnt      = mp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_resolve : scoreboard bench, directed corner cases plus random traffic.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_branch_resolve;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        mp;
    logic [31:0] redir;
    logic        ill;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready, pred_taken;
  logic [1:0]  kind;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm, pred_target;

  logic        in_ready, out_valid, taken, mispredict, illegal;
  logic [31:0] target, redirect_pc;
  logic [15:0] br_cnt, mp_cnt;

  logic        in_ready_s, out_valid_s, taken_s, mispredict_s, illegal_s;
  logic [31:0] target_s, redirect_pc_s;
  logic [1:0]  br_cnt_s, mp_cnt_s;

  branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal(illegal),
    .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  branch_resolve #(.XLEN(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .kind(kind), .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
    .out_valid(out_valid_s), .out_ready(out_ready), .taken(taken_s), .target(target_s),
    .mispredict(mispredict_s), .redirect_pc(redirect_pc_s), .illegal(illegal_s),
    .br_cnt(br_cnt_s), .mp_cnt(mp_cnt_s)
  );

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  int   exp_br = 0;
  int   exp_mp = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Reference: architectural meaning of each control-flow kind.
  function automatic res_t model(input logic [1:0] k, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im,
                                 input logic pt, input logic [31:0] ptg);
    res_t r;
    logic [31:0] seq;
    seq = p + 32'd4;
    r = '0;
    r.target = seq;
    if (k == 2'd1) begin
      case (f3)
        3'd0: r.taken = (a == b);
        3'd1: r.taken = (a != b);
        3'd4: r.taken = (int'(a) < int'(b));
        3'd5: r.taken = (int'(a) >= int'(b));
        3'd6: r.taken = (a < b);
        3'd7: r.taken = (a >= b);
        default: r.ill = 1'b1;
      endcase
      if (!r.ill) r.target = p + im;
    end else if (k == 2'd2) begin
      r.taken  = 1'b1;
      r.target = p + im;
    end else if (k == 2'd3) begin
      r.taken  = 1'b1;
      r.target = (a + im) & 32'hFFFF_FFFE;
    end
    r.mp    = !r.ill && ((r.taken != pt) || (r.taken && r.target != ptg));
    r.redir = r.taken ? r.target : seq;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_valid_s", out_valid_s, q.size() != 0);
      chk("in_ready", in_ready, (q.size() == 0 || out_ready) && !flush);
      chk("br_cnt", br_cnt, exp_br);
      chk("mp_cnt", mp_cnt, exp_mp);
      chk("br_cnt_sat", br_cnt_s, sat(exp_br, 2));
      chk("mp_cnt_sat", mp_cnt_s, sat(exp_mp, 2));
      if (q.size() != 0) begin
        chk("taken", taken, q[0].taken);
        chk("target", target, q[0].target);
        chk("mispredict", mispredict, q[0].mp);
        chk("redirect_pc", redirect_pc, q[0].redir);
        chk("illegal", illegal, q[0].ill);
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic iv, input logic [1:0] k, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] im,
                      input logic pt, input logic [31:0] ptg,
                      input logic ordy, input logic fl);
    res_t r;
    in_valid = iv; kind = k; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = im;
    pred_taken = pt; pred_target = ptg; out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    if (in_valid && in_ready) begin
      r = model(k, f3, a, b, p, im, pt, ptg);
      q.push_back(r);
      if (k != 2'd0 && !r.ill) exp_br++;
      if (r.mp) exp_mp++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", {out_valid, out_valid_s}, 2'b00);
    chk("rst_taken", {taken, taken_s}, 2'b00);
    chk("rst_mispredict", {mispredict, mispredict_s}, 2'b00);
    chk("rst_illegal", {illegal, illegal_s}, 2'b00);
    chk("rst_target", {target, target_s}, 64'd0);
    chk("rst_redirect", {redirect_pc, redirect_pc_s}, 64'd0);
    chk("rst_cnt", {br_cnt, mp_cnt, br_cnt_s, mp_cnt_s}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  k;
    logic [2:0]  f3;
    logic [31:0] a, b, p, im, ptg;
    logic        pt;
    res_t        r0;

    rst = 1'b1; in_valid = 0; kind = 0; funct3 = 0; rs1 = 0; rs2 = 0; pc = 0; imm = 0;
    pred_taken = 0; pred_target = 0; flush = 0; out_ready = 1;
    #2;
    chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_reset", in_ready, 1'b1);
    mon_en = 1'b1;

    step(1, 2'd1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 0, 0, 1, 0);
    step(1, 2'd1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 0, 0, 1, 0);
    step(1, 2'd3, 3'b000, 32'h1001, 32'd0, 32'h200, 32'h2, 1, 32'h1002, 1, 0);
    step(1, 2'd3, 3'b000, 32'h1001, 32'd0, 32'h200, 32'h2, 1, 32'h1003, 1, 0);
    step(1, 2'd0, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 0, 0, 1, 0);
    step(1, 2'd1, 3'b010, 32'd5, 32'd5, 32'h300, 32'h10, 0, 0, 1, 0);
    step(1, 2'd2, 3'b000, 32'd0, 32'd0, 32'h400, 32'h80, 1, 32'h480, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 2'd2, 3'b000, 32'd0, 32'd0, 32'h500 + i, 32'h4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 2'd1, 3'b001, i, 32'd9, 32'h600 + 32'(i * 4), 32'hFFFF_FFF0, 1, 32'h5F0 + 32'(i * 4), 1, 0);
    step(1, 2'd2, 3'b000, 32'd0, 32'd0, 32'h700, 32'h4, 1, 32'h704, 0, 0);
    step(0, 2'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(1, 2'd1, 3'b000, 32'd7, 32'd7, 32'h800, 32'h20, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      k   = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      p   = $urandom & 32'hFFFF_FFFC;
      im  = $urandom;
      pt  = 1'($urandom_range(0, 1));
      r0  = model(k, f3, a, b, p, im, pt, 32'd0);
      ptg = ($urandom_range(0, 2) != 0) ? r0.target : $urandom;
      step(1'($urandom_range(0, 9) < 8), k, f3, a, b, p, im, pt, ptg,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

    for (int i = 0; i < 3; i++)
      step(0, 2'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0);
    chk("drain_empty", q.size(), 0);

    step(1, 2'd1, 3'b000, 32'd3, 32'd3, 32'h900, 32'h10, 0, 0, 0, 0);
    step(1, 2'd1, 3'b000, 32'd3, 32'd3, 32'h900, 32'h10, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    q.delete();
    exp_br = 0;
    exp_mp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 2'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0);
    step(1, 2'd2, 3'b000, 32'd0, 32'd0, 32'hA00, 32'h8, 0, 0, 1, 0);
    step(0, 2'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the operand, PC and immediate width.
REQ-002 The block SHALL take parameter CNT_W, default 16, as the width of each statistics counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 kind  input  2  operation: 00 NONE, 01 BRANCH, 10 JAL, 11 JALR.
REQ-008 funct3  input  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-009 rs1, rs2  input  XLEN each  operands.
REQ-010 pc, imm  input  XLEN each  instruction PC and sign-extended immediate.
REQ-011 pred_taken  input  1  front-end prediction; pred_target  input  XLEN  predicted target.
REQ-012 flush  input  1  kill the held result.
REQ-013 out_valid  output  1  result held; out_ready  input  1  consumer accepts.
REQ-014 taken  output  1  resolved direction; target  output  XLEN  resolved target.
REQ-015 mispredict  output  1  redirect required; redirect_pc  output  XLEN  correct next PC.
REQ-016 illegal  output  1  unsupported funct3 (010/011) with kind=BRANCH.
REQ-017 br_cnt, mp_cnt  output  CNT_W each  resolved-control-flow count and mispredict count.

Function
REQ-018 A request SHALL be accepted when in_valid and in_ready are both high.
REQ-019 Results SHALL appear on the outputs exactly 1 cycle after acceptance, held in a single output register.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-021 Result outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous drain and accept (out_valid, out_ready and in_valid all high) SHALL load the new result with no bubble.
REQ-023 BRANCH: taken SHALL follow funct3, with signed compares for BLT/BGE and unsigned compares for BLTU/BGEU; target SHALL be pc+imm.
REQ-024 JAL: taken=1 and target=pc+imm.
REQ-025 JALR: taken=1 and target=(rs1+imm) with bit 0 cleared.
REQ-026 NONE: taken=0 and target=pc+4.
REQ-027 Illegal funct3: illegal=1, taken=0, mispredict=0, target=pc+4.
REQ-028 All additions SHALL be modulo 2^XLEN, wrapping silently with no carry out.
REQ-029 mispredict SHALL equal (taken != pred_taken) || (taken && target != pred_target), and SHALL be forced to 0 when illegal=1.
REQ-030 redirect_pc SHALL be target when taken=1 and pc+4 otherwise.
REQ-031 br_cnt SHALL increment on each accepted non-NONE, non-illegal request.
REQ-032 mp_cnt SHALL increment on each accepted request whose mispredict=1.
REQ-033 Both counters SHALL saturate at all-ones and never wrap.
REQ-034 Counters SHALL update in the cycle of acceptance.
REQ-035 flush=1 SHALL clear out_valid at the next edge, overriding a simultaneous accept (none can occur, since in_ready=0).
REQ-036 flush SHALL leave the counters unchanged.
REQ-037 When out_valid=0, the data outputs SHALL hold their last value and are don't-care.

Reset
REQ-038 On rst assertion, out_valid, taken, mispredict and illegal SHALL be 0, target and redirect_pc SHALL be 0, and br_cnt and mp_cnt SHALL be 0, immediately and independently of clk.
REQ-039 in_ready SHALL be 1 after reset whenever flush=0.
REQ-040 A result held when rst asserts SHALL be discarded.

Structure
REQ-041 The kind encodings, the funct3 branch encodings and the PC increment constant (4) SHALL live in the shared riscv_pkg package.
REQ-042 Condition evaluation SHALL be a parametrised combinational sub-module, branch_cmp (XLEN), with outputs taken and illegal.
REQ-043 branch_resolve SHALL own the handshake register, target adders, mispredict logic and counters.

Verification
REQ-044 BRANCH BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> next cycle: taken=1, mispredict=1, redirect_pc=pc+imm, mp_cnt=1.
REQ-045 BRANCH BLTU, same operands, pred_taken=0 -> taken=0, mispredict=0, redirect_pc=pc+4.
REQ-046 JALR with rs1=0x1001, imm=0x2, pred_target=0x1002 -> target=0x1002, mispredict=0; with pred_target=0x1003 -> mispredict=1.
REQ-047 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; release -> back-to-back transfers with no bubble.
REQ-048 pc=0xFFFFFFFC with kind=NONE -> redirect_pc=0x0; funct3=010 -> illegal=1, counters unchanged.
REQ-049 CNT_W=2, five mispredicting branches -> mp_cnt saturates at 3; rst mid-stream -> all outputs 0 immediately.
